axi4_lite_slave_regfile: RTL and testbench

- Parametrised AXI4-Lite slave that terminates the AW/W/B and AR/R channels onto an internal bank of NUM_REGS registers, each DATA_WIDTH bits wide.
- Successor to the fixed 32-bit channel pass-through top. It adds independent AW/W acceptance, byte-strobe writes, address decode with error responses, and back-pressure on B/R.
- Sits behind the interconnect as the endpoint for control/status registers.

---
 rtl/axi4_lite_pkg.sv | 21 ++
 rtl/axi4_lite_addr_decode.sv | 30 +++
 rtl/axi4_lite_slave_regfile.sv | 215 +++++++++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register-file slave.
// Response codes, write-path state encoding and strobe-width helper.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_ADDR,
      W_HAVE_DATA,
      W_RESP
   } wstate_e;

   function automatic int strb_width(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address to register index decode with range hit.
// Low (sub-word) address bits are dropped.
module axi4_lite_addr_decode
   import axi4_lite_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 32,
   parameter int          NUM_REGS   = 16,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic [ADDR_WIDTH-1:0]       addr,
   output logic [$clog2(NUM_REGS)-1:0] idx,
   output logic                        hit
);

   localparam int SH = $clog2(strb_width(DATA_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);

   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-1:0] word;

   always_comb begin
      off  = addr - BASE;
      word = off >> SH;
      idx  = word[$clog2(NUM_REGS)-1:0];
      hit  = (addr >= BASE) && (word < NREG);
   end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave terminating AW/W/B and AR/R onto a register bank.
// Optional macro AXI_LITE_PROT_CHECK_EN rejects unprivileged accesses.
module axi4_lite_slave_regfile
   import axi4_lite_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 32,
   parameter int          NUM_REGS   = 16,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic                       AWVALID,
   output logic                       AWREADY,
   input  logic [ADDR_WIDTH-1:0]      AWADDR,
   input  logic [2:0]                 AWPROT,
   input  logic                       WVALID,
   output logic                       WREADY,
   input  logic [DATA_WIDTH-1:0]      WDATA,
   input  logic [DATA_WIDTH/8-1:0]    WSTRB,
   output logic                       BVALID,
   input  logic                       BREADY,
   output logic [1:0]                 BRESP,
   input  logic                       ARVALID,
   output logic                       ARREADY,
   input  logic [ADDR_WIDTH-1:0]      ARADDR,
   input  logic [2:0]                 ARPROT,
   output logic                       RVALID,
   input  logic                       RREADY,
   output logic [DATA_WIDTH-1:0]      RDATA,
   output logic [1:0]                 RRESP
);

   localparam int STRB_W = strb_width(DATA_WIDTH);
   localparam int IDX_W  = $clog2(NUM_REGS);

   wstate_e                 state_q, state_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    arready_q, arready_d;
   logic                    bvalid_q, bvalid_d;
   logic                    rvalid_q, rvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    aw_held_q, aw_held_d;
   logic                    w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
   logic [2:0]              aw_prot_q, aw_prot_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             wr_hit, rd_hit;
   logic             wr_ok, rd_ok;
   logic             unused_prot;

   axi4_lite_addr_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR)
   ) u_wr_dec (
      .addr (aw_addr_q),
      .idx  (wr_idx),
      .hit  (wr_hit)
   );

   axi4_lite_addr_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BASE_ADDR  (BASE_ADDR)
   ) u_rd_dec (
      .addr (ARADDR),
      .idx  (rd_idx),
      .hit  (rd_hit)
   );

`ifdef AXI_LITE_PROT_CHECK_EN
   assign wr_ok       = wr_hit && aw_prot_q[0];
   assign rd_ok       = rd_hit && ARPROT[0];
   assign unused_prot = ^{aw_prot_q[2:1], ARPROT[2:1]};
`else
   assign wr_ok       = wr_hit;
   assign rd_ok       = rd_hit;
   assign unused_prot = ^{aw_prot_q, ARPROT};
`endif

   always_comb begin
      state_d   = state_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      aw_addr_d = aw_addr_q;
      aw_prot_d = aw_prot_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      regs_d    = regs_q;

      if (AWVALID && awready_q) begin
         aw_held_d = 1'b1;
         aw_addr_d = AWADDR;
         aw_prot_d = AWPROT;
      end
      if (WVALID && wready_q) begin
         w_held_d = 1'b1;
         wdata_d  = WDATA;
         wstrb_d  = WSTRB;
      end

      unique case (state_q)
         W_RESP: begin
            if (BREADY) begin
               bvalid_d  = 1'b0;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               state_d   = W_IDLE;
            end
         end
         default: begin
            if (aw_held_q && w_held_q) begin
               if (wr_ok) begin
                  for (int b = 0; b < STRB_W; b++) begin
                     if (wstrb_q[b]) begin
                        regs_d[wr_idx][8*b +: 8] = wdata_q[8*b +: 8];
                     end
                  end
               end
               bvalid_d = 1'b1;
               bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
               state_d  = W_RESP;
            end else if (aw_held_d) begin
               state_d = W_HAVE_ADDR;
            end else if (w_held_d) begin
               state_d = W_HAVE_DATA;
            end else begin
               state_d = W_IDLE;
            end
         end
      endcase

      awready_d = !aw_held_d && (state_d != W_RESP);
      wready_d  = !w_held_d && (state_d != W_RESP);
   end

   // Read data is sampled from the pre-write bank, so a same-cycle write
   // to the same register is not visible to this read.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ARVALID && arready_q) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_ok ? regs_q[rd_idx] : '0;
         rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && RREADY) begin
         rvalid_d = 1'b0;
      end
      arready_d = !rvalid_d;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         aw_prot_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_addr_q <= aw_addr_d;
         aw_prot_q <= aw_prot_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         regs_q    <= regs_d;
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign ARREADY = arready_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for axi4_lite_slave_regfile: directed AXI-Lite traffic,
// expected B/R responses queued at issue and checked by a monitor.
module tb_axi4_lite_slave_regfile;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] AWADDR = '0;
   logic [2:0]  AWPROT = 3'b001;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        BVALID;
   logic        BREADY = 1'b1;
   logic [1:0]  BRESP;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] ARADDR = '0;
   logic [2:0]  ARPROT = 3'b001;
   logic        RVALID;
   logic        RREADY = 1'b1;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];

   axi4_lite_slave_regfile dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .AWADDR  (AWADDR),
      .AWPROT  (AWPROT),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .WDATA   (WDATA),
      .WSTRB   (WSTRB),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .BRESP   (BRESP),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .ARADDR  (ARADDR),
      .ARPROT  (ARPROT),
      .RVALID  (RVALID),
      .RREADY  (RREADY),
      .RDATA   (RDATA),
      .RRESP   (RRESP)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever a response handshake is visible.
   always @(negedge ACLK) begin
      if (ARESETn && BVALID && BREADY) begin
         if (exp_b.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_unexpected: got BRESP %b required none", BRESP);
         end else begin
            chk("bresp", 64'(BRESP), 64'(exp_b.pop_front()));
         end
      end
      if (ARESETn && RVALID && RREADY) begin
         if (exp_r.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL r_unexpected: got %h/%b required none",
                     RDATA, RRESP);
         end else begin
            chk("rdata_rresp", 64'({RDATA, RRESP}), 64'(exp_r.pop_front()));
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] resp);
      chk("aw_w_ready", 64'({AWREADY, WREADY}), 64'(2'b11));
      exp_b.push_back(resp);
      AWVALID = 1'b1;
      AWADDR  = a;
      WVALID  = 1'b1;
      WDATA   = d;
      WSTRB   = s;
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      chk("b_early", 64'(BVALID), 64'(0));
      @(posedge ACLK);
      #1;
      chk("b_lat", 64'(BVALID), 64'(1));
      if (BREADY) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] resp);
      chk("ar_ready", 64'(ARREADY), 64'(1));
      exp_r.push_back({d, resp});
      ARVALID = 1'b1;
      ARADDR  = a;
      @(posedge ACLK);
      #1;
      ARVALID = 1'b0;
      chk("r_lat", 64'(RVALID), 64'(1));
      if (RREADY) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("reset_outs",
          64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}),
          64'(0));
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      chk("ready_after_reset", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));

      wr(32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
      rd(32'h4, 32'hDEADBEEF, 2'b00);

      // W first, AW three cycles later
      chk("w_first_ready", 64'(WREADY), 64'(1));
      exp_b.push_back(2'b00);
      WVALID = 1'b1;
      WDATA  = 32'hCAFEF00D;
      WSTRB  = 4'hF;
      @(posedge ACLK);
      #1;
      WVALID = 1'b0;
      chk("w_drop", 64'({AWREADY, WREADY}), 64'(2'b10));
      repeat (2) begin
         @(posedge ACLK);
         #1;
      end
      chk("w_wait", 64'({WREADY, BVALID}), 64'(2'b00));
      AWVALID = 1'b1;
      AWADDR  = 32'h8;
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      chk("b_early_wfirst", 64'(BVALID), 64'(0));
      @(posedge ACLK);
      #1;
      chk("b_lat_wfirst", 64'(BVALID), 64'(1));
      @(posedge ACLK);
      #1;
      rd(32'h8, 32'hCAFEF00D, 2'b00);

      wr(32'h4, 32'h12345678, 4'b0011, 2'b00);
      rd(32'h4, 32'hDEAD5678, 2'b00);

      wr(32'h40, 32'hFFFFFFFF, 4'hF, 2'b10);
      rd(32'h40, 32'h0, 2'b10);
      rd(32'h0, 32'h0, 2'b00);
      rd(32'h4, 32'hDEAD5678, 2'b00);

      wr(32'hC, 32'h0, 4'h0, 2'b00);
      rd(32'hC, 32'h0, 2'b00);

      // Back-pressure on B and R
      BREADY = 1'b0;
      RREADY = 1'b0;
      wr(32'hC, 32'h11112222, 4'hF, 2'b00);
      rd(32'h4, 32'hDEAD5678, 2'b00);
      AWVALID = 1'b1;
      AWADDR  = 32'h10;
      for (int i = 0; i < 5; i++) begin
         @(posedge ACLK);
         #1;
         chk("hold_stable",
             64'({BVALID, BRESP, RVALID, RDATA, RRESP,
                  AWREADY, WREADY, ARREADY}),
             64'({1'b1, 2'b00, 1'b1, 32'hDEAD5678, 2'b00, 3'b000}));
      end
      BREADY = 1'b1;
      RREADY = 1'b1;
      @(posedge ACLK);
      #1;
      chk("reopen", 64'({BVALID, RVALID, AWREADY, WREADY, ARREADY}),
          64'(5'b00111));
      exp_b.push_back(2'b00);
      WVALID = 1'b1;
      WDATA  = 32'h00000055;
      WSTRB  = 4'hF;
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      @(posedge ACLK);
      #1;
      chk("b_lat_reopen", 64'(BVALID), 64'(1));
      @(posedge ACLK);
      #1;
      rd(32'hC, 32'h11112222, 2'b00);
      rd(32'h10, 32'h00000055, 2'b00);

      // Reset between AW and W
      AWVALID = 1'b1;
      AWADDR  = 32'h14;
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      chk("aw_taken", 64'({AWREADY, WREADY}), 64'(2'b01));
      ARESETn = 1'b0;
      #1;
      chk("reset_mid",
          64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}),
          64'(0));
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      chk("ready_after_reset2", 64'({AWREADY, WREADY, ARREADY}),
          64'(3'b111));
      rd(32'h4, 32'h0, 2'b00);
      rd(32'hC, 32'h0, 2'b00);
      wr(32'h14, 32'hA5A5A5A5, 4'hF, 2'b00);
      rd(32'h14, 32'hA5A5A5A5, 2'b00);

`ifdef AXI_LITE_PROT_CHECK_EN
      AWPROT = 3'b000;
      wr(32'h18, 32'h77, 4'hF, 2'b10);
      AWPROT = 3'b001;
      rd(32'h18, 32'h0, 2'b00);
      ARPROT = 3'b000;
      rd(32'h14, 32'h0, 2'b10);
      ARPROT = 3'b001;
`endif

      repeat (4) @(posedge ACLK);
      #1;
      chk("b_queue_empty", 64'(exp_b.size()), 64'(0));
      chk("r_queue_empty", 64'(exp_r.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
